// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - shared memory port bundle: two requesters, memory side, status
//
// Purpose: groups the handshake and bus signals of mem_port_arbiter.
//   master modport: the arbiter's view (drives readies, memory request, status).
//   slave modport : the environment's view (requesters and memory model).
// Signals:
//   req{0,1}_valid/addr/wdata/we  requester -> arbiter
//   req{0,1}_ready/rdata          arbiter -> requester
//   mem_req/addr/wdata/we         arbiter -> memory
//   mem_valid/rdata               memory -> arbiter
//   owner/busy/timeout_err        arbiter status

interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic [3:0]        req0_we;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_rdata;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic [3:0]        req1_we;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_rdata;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_we;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_rdata;

  logic              owner;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  req0_valid, req0_addr, req0_wdata, req0_we,
    output req0_ready, req0_rdata,
    input  req1_valid, req1_addr, req1_wdata, req1_we,
    output req1_ready, req1_rdata,
    output mem_req, mem_addr, mem_wdata, mem_we,
    input  mem_valid, mem_rdata,
    output owner, busy, timeout_err
  );

  modport slave (
    output req0_valid, req0_addr, req0_wdata, req0_we,
    input  req0_ready, req0_rdata,
    output req1_valid, req1_addr, req1_wdata, req1_we,
    input  req1_ready, req1_rdata,
    input  mem_req, mem_addr, mem_wdata, mem_we,
    output mem_valid, mem_rdata,
    input  owner, busy, timeout_err
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one memory port between core and loader
//
// Purpose: grants the single memory port to requester 0 (core) or requester 1
//   (debug/loader), carries one registered request at a time through
//   IDLE -> ISSUE -> WAIT -> RESP, and aborts a transaction whose memory never
//   answers within TIMEOUT_CYCLES wait cycles.
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      mem_port_arbiter_if.master (requesters, memory side, status)

module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mem_port_arbiter_if.master   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              abort_q, abort_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        we_q, we_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic              grant;
  logic              cap_en;
  logic [DATA_W-1:0] cap_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;   // core wins the first contested grant
      abort_q      <= 1'b0;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      we_q         <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      abort_q      <= abort_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    abort_d      = abort_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    cap_en       = 1'b0;
    cap_data     = '0;
    // Contested: the side that did not win last time; otherwise whoever is valid.
    grant        = (bus.req0_valid && bus.req1_valid) ? ~last_grant_q : bus.req1_valid;

    case (state_q)
      S_IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          owner_d      = grant;
          last_grant_d = grant;
          addr_d       = grant ? bus.req1_addr  : bus.req0_addr;
          wdata_d      = grant ? bus.req1_wdata : bus.req0_wdata;
          we_d         = grant ? bus.req1_we    : bus.req0_we;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        abort_d = 1'b0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A response in the last allowed cycle still counts as a normal completion.
        if (bus.mem_valid) begin
          cap_en   = 1'b1;
          cap_data = (we_q == 4'b0) ? bus.mem_rdata : '0;
          state_d  = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          cap_en   = 1'b1;
          cap_data = '0;
          abort_d  = 1'b1;
          state_d  = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cap_en) begin
      if (owner_q) begin
        rdata1_d = cap_data;
      end else begin
        rdata0_d = cap_data;
      end
    end
  end

  // Pulses are decoded from state so an asynchronous reset drops them at once.
  assign bus.mem_req     = (state_q == S_ISSUE);
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.req0_ready  = (state_q == S_RESP) && !owner_q;
  assign bus.req1_ready  = (state_q == S_RESP) &&  owner_q;
  assign bus.timeout_err = (state_q == S_RESP) &&  abort_q;
  assign bus.owner       = owner_q;
  assign bus.mem_addr    = addr_q;
  assign bus.mem_wdata   = wdata_q;
  assign bus.mem_we      = we_q;
  assign bus.req0_rdata  = rdata0_q;
  assign bus.req1_rdata  = rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus.req0_valid = 0; bus.req0_addr = 0; bus.req0_wdata = 0; bus.req0_we = 0;
    bus.req1_valid = 0; bus.req1_addr = 0; bus.req1_wdata = 0; bus.req1_we = 0;
    bus.mem_valid  = 0; bus.mem_rdata = 0;

    // Reset state
    tick();
    chk("rst_busy",    bus.busy, 0);
    chk("rst_mem_req", bus.mem_req, 0);
    chk("rst_ready0",  bus.req0_ready, 0);
    chk("rst_ready1",  bus.req1_ready, 0);
    chk("rst_tmo",     bus.timeout_err, 0);
    chk("rst_owner",   bus.owner, 0);
    chk("rst_addr",    bus.mem_addr, 0);
    chk("rst_we",      bus.mem_we, 0);
    chk("rst_rdata0",  bus.req0_rdata, 0);
    tick();
    reset_n = 1'b1;
    tick();

    // Single core read, L=1
    bus.req0_valid = 1; bus.req0_addr = 32'h100; bus.req0_we = 4'h0;
    chk("rd_busy_pre", bus.busy, 0);
    tick();
    chk("rd_issue_req",  bus.mem_req, 1);
    chk("rd_issue_addr", bus.mem_addr, 32'h100);
    chk("rd_issue_own",  bus.owner, 0);
    chk("rd_issue_busy", bus.busy, 1);
    tick();
    chk("rd_wait_req",   bus.mem_req, 0);
    chk("rd_wait_rdy",   bus.req0_ready, 0);
    chk("rd_wait_busy",  bus.busy, 1);
    bus.mem_valid = 1; bus.mem_rdata = 32'hDEADBEEF;
    tick();
    bus.mem_valid = 0;
    chk("rd_resp_rdy",   bus.req0_ready, 1);
    chk("rd_resp_rdy1",  bus.req1_ready, 0);
    chk("rd_resp_data",  bus.req0_rdata, 32'hDEADBEEF);
    chk("rd_resp_busy",  bus.busy, 1);
    bus.req0_valid = 0;
    tick();
    chk("rd_idle_rdy",   bus.req0_ready, 0);
    chk("rd_idle_busy",  bus.busy, 0);
    chk("rd_hold_data",  bus.req0_rdata, 32'hDEADBEEF);
    // Stray mem_valid in IDLE is ignored
    bus.mem_valid = 1; bus.mem_rdata = 32'h0BAD0BAD;
    tick();
    bus.mem_valid = 0;
    chk("stray_busy",    bus.busy, 0);
    chk("stray_data",    bus.req0_rdata, 32'hDEADBEEF);
    tick();

    // Loader write, L=4
    bus.req1_valid = 1; bus.req1_addr = 32'h200; bus.req1_wdata = 32'h12345678; bus.req1_we = 4'hF;
    tick();
    chk("wr_issue_req",  bus.mem_req, 1);
    chk("wr_issue_addr", bus.mem_addr, 32'h200);
    chk("wr_issue_wd",   bus.mem_wdata, 32'h12345678);
    chk("wr_issue_we",   bus.mem_we, 4'hF);
    chk("wr_issue_own",  bus.owner, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wr_wait_rdy1", bus.req1_ready, 0);
      chk("wr_wait_req",  bus.mem_req, 0);
    end
    tick();
    bus.mem_valid = 1; bus.mem_rdata = 32'hFFFFFFFF;
    tick();
    bus.mem_valid = 0;
    chk("wr_resp_rdy1",  bus.req1_ready, 1);
    chk("wr_resp_rdy0",  bus.req0_ready, 0);
    chk("wr_resp_data",  bus.req1_rdata, 0);
    chk("wr_resp_tmo",   bus.timeout_err, 0);
    bus.req1_valid = 0;
    tick();
    chk("wr_idle_rdy1",  bus.req1_ready, 0);

    // Simultaneous requests right after reset: grants alternate 0,1,0,1
    reset_n = 0;
    tick();
    reset_n = 1;
    bus.req0_valid = 1; bus.req0_addr = 32'h300; bus.req0_we = 0;
    bus.req1_valid = 1; bus.req1_addr = 32'h400; bus.req1_we = 0;
    for (int k = 0; k < 4; k++) begin
      logic        exp_own;
      logic [31:0] exp_data;
      exp_own  = k[0];
      exp_data = 32'hA0000000 + 32'(k);
      tick();
      chk("rr_own",  bus.owner, exp_own);
      chk("rr_addr", bus.mem_addr, exp_own ? 32'h400 : 32'h300);
      tick();
      bus.mem_valid = 1; bus.mem_rdata = exp_data;
      tick();
      bus.mem_valid = 0;
      chk("rr_rdy0", bus.req0_ready, !exp_own);
      chk("rr_rdy1", bus.req1_ready, exp_own);
      chk("rr_data", exp_own ? bus.req1_rdata : bus.req0_rdata, exp_data);
      if (k == 3) begin
        bus.req0_valid = 0; bus.req1_valid = 0;
      end
      tick();
      chk("rr_idle", bus.busy, 0);
    end

    // Timeout: no response, 8 WAIT cycles then abort
    bus.req0_valid = 1; bus.req0_addr = 32'h500; bus.req0_we = 0;
    tick();
    chk("to_issue", bus.mem_req, 1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("to_wait_rdy", bus.req0_ready, 0);
      chk("to_wait_err", bus.timeout_err, 0);
    end
    tick();
    chk("to_resp_rdy",  bus.req0_ready, 1);
    chk("to_resp_err",  bus.timeout_err, 1);
    chk("to_resp_data", bus.req0_rdata, 0);
    bus.req0_valid = 0;
    tick();
    chk("to_idle_err",  bus.timeout_err, 0);
    tick();
    bus.mem_valid = 1; bus.mem_rdata = 32'h55555555;
    tick();
    bus.mem_valid = 0;
    chk("to_late_rdy",  bus.req0_ready, 0);
    chk("to_late_busy", bus.busy, 0);
    chk("to_late_data", bus.req0_rdata, 0);

    // Reset two cycles into WAIT
    bus.req0_valid = 1; bus.req0_addr = 32'h600;
    tick();
    tick();
    tick();
    chk("rw_pre_busy", bus.busy, 1);
    reset_n = 0;
    #1;
    chk("rw_busy", bus.busy, 0);
    chk("rw_req",  bus.mem_req, 0);
    chk("rw_rdy",  bus.req0_ready, 0);
    chk("rw_err",  bus.timeout_err, 0);
    bus.req1_valid = 1; bus.req1_addr = 32'h700; bus.req1_we = 0;
    tick();
    reset_n = 1;
    tick();
    chk("rw_grant_own",  bus.owner, 0);
    chk("rw_grant_addr", bus.mem_addr, 32'h600);
    tick();
    bus.mem_valid = 1; bus.mem_rdata = 32'h66;
    tick();
    bus.mem_valid = 0;
    chk("rw_done_rdy", bus.req0_ready, 1);
    bus.req0_valid = 0; bus.req1_valid = 0;
    tick();

    // Back-to-back core requests
    bus.req0_valid = 1; bus.req0_addr = 32'h100;
    tick();
    chk("bb_addr1", bus.mem_addr, 32'h100);
    tick();
    bus.mem_valid = 1; bus.mem_rdata = 32'h11;
    tick();
    bus.mem_valid = 0;
    chk("bb_rdy1", bus.req0_ready, 1);
    bus.req0_valid = 0;
    tick();
    chk("bb_idle_busy", bus.busy, 0);
    chk("bb_idle_req",  bus.mem_req, 0);
    bus.req0_valid = 1; bus.req0_addr = 32'h104;
    tick();
    chk("bb_issue2", bus.mem_req, 1);
    chk("bb_addr2",  bus.mem_addr, 32'h104);
    tick();
    bus.req0_valid = 0;   // illegal early drop: transaction still completes
    bus.mem_valid = 1; bus.mem_rdata = 32'h22;
    tick();
    bus.mem_valid = 0;
    chk("bb_rdy2",  bus.req0_ready, 1);
    chk("bb_data2", bus.req0_rdata, 32'h22);
    tick();
    chk("bb_end_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
